// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one ALU between two requesters.
// Registers ALU operands, captures result/flags, holds response until consumed.
module alu_share_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [N-1:0]     req_a0,
  input  logic [N-1:0]     req_b0,
  input  logic [N-1:0]     req_a1,
  input  logic [N-1:0]     req_b1,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_control,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [N-1:0]     rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MOD = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MAX = 4'd9;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             div0_q, div0_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [N-1:0]     res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       grant;
  logic             sel;
  logic [3:0]       sel_op;
  logic [N-1:0]     sel_a;
  logic [N-1:0]     sel_b;
  logic             sel_inv;
  logic             sel_div0;

  // Grant only in IDLE; a contested grant goes to the pointer's channel
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Mux the granted channel's request and classify it
  always_comb begin
    sel      = grant[1];
    sel_op   = sel ? req_op1 : req_op0;
    sel_a    = sel ? req_a1 : req_a0;
    sel_b    = sel ? req_b1 : req_b0;
    sel_inv  = sel_op > OP_MAX;
    sel_div0 = ((sel_op == OP_MOD) || (sel_op == OP_DIV)) &&
               (sel_b == '0);
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    div0_d  = div0_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    res_d   = res_q;
    flg_d   = flg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d = sel;
          a_d     = sel_a;
          b_d     = sel_b;
          div0_d  = sel_div0;
          if (sel_inv) begin
            // Never present an undefined opcode to the ALU
            ctl_d   = 4'd0;
            res_d   = '0;
            flg_d   = 4'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            ctl_d   = sel_op;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flg_d   = {alu_v, alu_c, alu_n, alu_z};
        err_d   = div0_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          cnt_d   = cnt_q + 1'b1;
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= 4'd0;
      res_q   <= '0;
      flg_q   <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      div0_q  <= div0_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    req_ready   = grant;
    alu_a       = a_q;
    alu_b       = b_q;
    alu_control = ctl_q;
    rsp_valid   = 2'b00;
    if (state_q == RESP) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end
    rsp_result  = res_q;
    rsp_flags   = flg_q;
    rsp_err     = err_q;
    busy        = state_q != IDLE;
    op_count    = cnt_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural 4-bit ALU.
// Counter width 2 so the wrap of op_count is reachable.
module tb_alu_share_arbiter;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0, req_op1;
  logic [N-1:0]     req_a0, req_b0, req_a1, req_b1;
  logic [N-1:0]     alu_a, alu_b;
  logic [3:0]       alu_control;
  logic [N-1:0]     alu_result;
  logic             alu_v, alu_c, alu_n, alu_z;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [N-1:0]     rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int vec  = 0;
  int miss = 0;

  alu_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result),
    .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared ALU: c is carry on add and no-borrow on sub; /0 and %0 give 0
  logic [N:0] m_sum;
  always_comb begin
    m_sum      = '0;
    alu_result = '0;
    alu_v      = 1'b0;
    alu_c      = 1'b0;
    case (alu_control)
      4'd0: begin
        m_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = m_sum[N-1:0];
        alu_c      = m_sum[N];
        alu_v      = (alu_a[N-1] == alu_b[N-1]) &&
                     (alu_result[N-1] != alu_a[N-1]);
      end
      4'd1: begin
        alu_result = alu_a - alu_b;
        alu_c      = alu_a >= alu_b;
        alu_v      = (alu_a[N-1] != alu_b[N-1]) &&
                     (alu_result[N-1] != alu_a[N-1]);
      end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = alu_a >> alu_b;
      4'd6: alu_result = alu_a << alu_b;
      4'd7: alu_result = (alu_b == 0) ? '0 : alu_a % alu_b;
      4'd8: alu_result = alu_a * alu_b;
      4'd9: alu_result = (alu_b == 0) ? '0 : alu_a / alu_b;
      default: alu_result = '0;
    endcase
    alu_n = alu_result[N-1];
    alu_z = alu_result == '0;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss + 1);
    $fatal(1, "timeout");
  end

  logic [1:0] g_exp [3];
  logic [3:0] c_exp [3];
  logic [3:0] r_exp [3];
  logic [3:0] f_exp [3];
  logic [1:0] n_exp [3];
  logic [1:0] m_cnt [5];

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    #2;
    chk("rst_ready", {6'd0, req_ready}, 8'h00);
    chk("rst_alu_ab", {alu_a, alu_b}, 8'h00);
    chk("rst_ctl", {4'd0, alu_control}, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_err, busy, rsp_result}, 8'h00);
    chk("rst_flags", {4'd0, rsp_flags}, 8'h00);
    chk("rst_count", {6'd0, op_count}, 8'h00);
    tick; tick;
    rst = 1'b0;
    tick;

    // Reset asserted between edges while in EXEC
    req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 4'h1; req_b0 = 4'h1;
    tick;
    req_valid = 2'b00;
    chk("mid_busy", {7'd0, busy}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_busy0", {7'd0, busy}, 8'h00);
    chk("mid_rspv", {6'd0, rsp_valid}, 8'h00);
    chk("mid_alu", {alu_a, alu_control}, 8'h00);
    chk("mid_count", {6'd0, op_count}, 8'h00);
    rst = 1'b0;
    tick;
    req_valid = 2'b11;
    #1;
    chk("mid_ptr", {6'd0, req_ready}, 8'h01);
    req_valid = 2'b00;
    tick; tick;
    chk("mid_norsp", {6'd0, rsp_valid}, 8'h00);

    // Channel 0 add 7+1, response held while rsp_ready low
    req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 4'h7; req_b0 = 4'h1;
    #1;
    chk("add_ready", {6'd0, req_ready}, 8'h01);
    tick;
    req_valid = 2'b00;
    chk("add_ctl", {4'd0, alu_control}, 8'h00);
    chk("add_ab", {alu_a, alu_b}, 8'h71);
    chk("add_rspv0", {6'd0, rsp_valid}, 8'h00);
    tick;
    chk("add_rspv", {6'd0, rsp_valid}, 8'h01);
    chk("add_res", {4'd0, rsp_result}, 8'h08);
    chk("add_flags", {4'd0, rsp_flags}, 8'h0A);
    chk("add_err", {7'd0, rsp_err}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("add_hold", {rsp_valid, rsp_err, 1'b0, rsp_result}, 8'h48);
      chk("add_hold_f", {rsp_flags, 2'd0, op_count}, 8'hA0);
    end
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    chk("add_consume", {6'd0, rsp_valid}, 8'h00);
    chk("add_count", {6'd0, op_count}, 8'h01);
    chk("add_idle", {7'd0, busy}, 8'h00);

    // Channel 1 divide by zero
    req_valid = 2'b10; req_op1 = 4'd9; req_a1 = 4'h9; req_b1 = 4'h0;
    #1;
    chk("div_ready", {6'd0, req_ready}, 8'h02);
    tick;
    req_valid = 2'b00;
    chk("div_ctl", {4'd0, alu_control}, 8'h09);
    tick;
    chk("div_rspv", {6'd0, rsp_valid}, 8'h02);
    chk("div_err", {7'd0, rsp_err}, 8'h01);
    chk("div_res", {4'd0, rsp_result}, 8'h00);
    chk("div_flags", {4'd0, rsp_flags}, 8'h01);
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;
    chk("div_count", {6'd0, op_count}, 8'h02);

    // Both channels contend every cycle
    g_exp = '{2'b01, 2'b10, 2'b01};
    c_exp = '{4'd1, 4'd2, 4'd1};
    r_exp = '{4'h2, 4'h8, 4'h2};
    f_exp = '{4'b0100, 4'b0010, 4'b0100};
    n_exp = '{2'd3, 2'd0, 2'd1};
    req_op0 = 4'd1; req_a0 = 4'h5; req_b0 = 4'h3;
    req_op1 = 4'd2; req_a1 = 4'hC; req_b1 = 4'hA;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr_grant", {6'd0, req_ready}, {6'd0, g_exp[i]});
      tick;
      chk("rr_ready_ex", {6'd0, req_ready}, 8'h00);
      chk("rr_ctl", {4'd0, alu_control}, {4'd0, c_exp[i]});
      tick;
      chk("rr_rspv", {6'd0, rsp_valid}, {6'd0, g_exp[i]});
      chk("rr_res", {rsp_flags, rsp_result}, {f_exp[i], r_exp[i]});
      chk("rr_ready_rs", {6'd0, req_ready}, 8'h00);
      tick;
      chk("rr_count", {6'd0, op_count}, {6'd0, n_exp[i]});
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Invalid opcode on channel 0 goes straight to RESP
    req_valid = 2'b01; req_op0 = 4'hC; req_a0 = 4'h3; req_b0 = 4'h3;
    #1;
    chk("inv_ready", {6'd0, req_ready}, 8'h01);
    tick;
    req_valid = 2'b00;
    chk("inv_rspv", {6'd0, rsp_valid}, 8'h01);
    chk("inv_err", {7'd0, rsp_err}, 8'h01);
    chk("inv_resf", {rsp_flags, rsp_result}, 8'h00);
    chk("inv_ctl", {4'd0, alu_control}, 8'h00);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    chk("inv_count", {6'd0, op_count}, 8'h02);

    rst = 1'b1;
    #1;
    chk("rst2_count", {6'd0, op_count}, 8'h00);
    rst = 1'b0;
    tick;

    // Five back-to-back multiplies, counter wraps; non-owner ready ignored
    m_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    req_valid = 2'b01; req_op0 = 4'd8; req_a0 = 4'h3; req_b0 = 4'h2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("mul_ready", {6'd0, req_ready}, 8'h01);
      tick;
      chk("mul_ctl", {4'd0, alu_control}, 8'h08);
      tick;
      chk("mul_rsp", {rsp_valid, rsp_err, 1'b0, rsp_result}, 8'h46);
      if (i == 0) begin
        rsp_ready = 2'b10;
        tick; tick;
        chk("nonown_rspv", {6'd0, rsp_valid}, 8'h01);
        chk("nonown_busy", {7'd0, busy}, 8'h01);
        chk("nonown_cnt", {6'd0, op_count}, 8'h00);
      end
      rsp_ready = 2'b01;
      tick;
      rsp_ready = 2'b00;
      chk("mul_count", {6'd0, op_count}, {6'd0, m_cnt[i]});
      chk("mul_done", {6'd0, rsp_valid}, 8'h00);
    end
    req_valid = 2'b00;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
